// File: rtl/mem_stage.sv
// Purpose: MINA2000 memory-access stage; owns MEM/WB, drives a single-outstanding valid/ack bus.
// Latency: non-memory op 1 cycle; memory op 2 + W cycles (W = wait cycles before bus_ack).
// Backpressure: mem_stall (combinational) holds EX/MEM from op issue until the ack or timeout cycle.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   mem_params                 EX/MEM bundle (rd_addr, mem_op, rd_data = ALU result / ea, mem_data)
//   mem_stall, mem_fault       hold request to earlier stages; one-cycle misalign/timeout pulse
//   wb_rd_addr, wb_rd_data     MEM/WB register (rd_addr 0 = no writeback)
//   bus_req/we/addr/be/wdata   registered bus request, held stable while waiting
//   bus_ack, bus_rdata         bus completion and load data

package mem_stage_pkg;
  localparam int RD_W = 5;

  typedef enum logic [3:0] {
    MEM_OP_NONE = 4'd0,
    MEM_OP_LB,
    MEM_OP_LBU,
    MEM_OP_LH,
    MEM_OP_LHU,
    MEM_OP_LW,
    MEM_OP_SB,
    MEM_OP_SH,
    MEM_OP_SW
  } mem_op_t;

  typedef struct packed {
    logic [RD_W-1:0] rd_addr;
    mem_op_t         mem_op;
    logic [31:0]     rd_data;
    logic [31:0]     mem_data;
  } mem_params_t;
endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  mem_params_t     mem_params,
  output logic            mem_stall,
  output logic            mem_fault,
  output logic [RD_W-1:0] wb_rd_addr,
  output logic [31:0]     wb_rd_data,
  output logic            bus_req,
  output logic            bus_we,
  output logic [31:0]     bus_addr,
  output logic [3:0]      bus_be,
  output logic [31:0]     bus_wdata,
  input  logic            bus_ack,
  input  logic [31:0]     bus_rdata
);

  localparam int TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic {ST_IDLE, ST_BUS} state_t;

  state_t          state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic            bus_req_q, bus_req_d;
  logic            bus_we_q, bus_we_d;
  logic [31:0]     bus_addr_q, bus_addr_d;
  logic [3:0]      bus_be_q, bus_be_d;
  logic [31:0]     bus_wdata_q, bus_wdata_d;
  mem_op_t         op_q, op_d;
  logic [1:0]      off_q, off_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic [RD_W-1:0] wb_rd_addr_q, wb_rd_addr_d;
  logic [31:0]     wb_rd_data_q, wb_rd_data_d;
  logic            mem_fault_q, mem_fault_d;

  // Decode of the incoming op
  logic [1:0]  ea_off;
  logic        is_mem, is_store, misaligned;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;

  always_comb begin
    ea_off     = mem_params.rd_data[1:0];
    is_mem     = 1'b1;
    is_store   = 1'b0;
    misaligned = 1'b0;
    be_in      = 4'b0000;
    wdata_in   = mem_params.mem_data;
    case (mem_params.mem_op)
      MEM_OP_LB, MEM_OP_LBU: be_in = 4'b0001 << ea_off;
      MEM_OP_SB: begin
        is_store = 1'b1;
        be_in    = 4'b0001 << ea_off;
        wdata_in = {4{mem_params.mem_data[7:0]}};
      end
      MEM_OP_LH, MEM_OP_LHU: begin
        misaligned = ea_off[0];
        be_in      = 4'b0011 << ea_off;
      end
      MEM_OP_SH: begin
        is_store   = 1'b1;
        misaligned = ea_off[0];
        be_in      = 4'b0011 << ea_off;
        wdata_in   = {2{mem_params.mem_data[15:0]}};
      end
      MEM_OP_LW: begin
        misaligned = |ea_off;
        be_in      = 4'b1111;
      end
      MEM_OP_SW: begin
        is_store   = 1'b1;
        misaligned = |ea_off;
        be_in      = 4'b1111;
      end
      default: is_mem = 1'b0;
    endcase
  end

  // Load extraction uses the offset captured at issue, since bus_addr is word-aligned
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  always_comb begin
    byte_sel = 8'(bus_rdata >> {off_q, 3'b000});
    half_sel = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (op_q)
      MEM_OP_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      MEM_OP_LBU: load_data = {24'd0, byte_sel};
      MEM_OP_LH:  load_data = {{16{half_sel[15]}}, half_sel};
      MEM_OP_LHU: load_data = {16'd0, half_sel};
      default:    load_data = bus_rdata;
    endcase
  end

  logic tmo_terminal;
  logic stall_c;

  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_be_d     = bus_be_q;
    bus_wdata_d  = bus_wdata_q;
    op_d         = op_q;
    off_d        = off_q;
    rd_d         = rd_q;
    wb_rd_addr_d = wb_rd_addr_q;
    wb_rd_data_d = wb_rd_data_q;
    mem_fault_d  = 1'b0;
    stall_c      = 1'b0;
    tmo_terminal = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_W'(TMO_LAST));

    case (state_q)
      ST_IDLE: begin
        if (!is_mem) begin
          wb_rd_addr_d = mem_params.rd_addr;
          wb_rd_data_d = mem_params.rd_data;
        end else if (misaligned) begin
          mem_fault_d  = 1'b1;
          wb_rd_addr_d = '0;
          wb_rd_data_d = '0;
        end else begin
          stall_c     = 1'b1;
          state_d     = ST_BUS;
          tmo_d       = '0;
          bus_req_d   = 1'b1;
          bus_we_d    = is_store;
          bus_addr_d  = {mem_params.rd_data[31:2], 2'b00};
          bus_be_d    = be_in;
          bus_wdata_d = wdata_in;
          op_d        = mem_params.mem_op;
          off_d       = ea_off;
          rd_d        = mem_params.rd_addr;
        end
      end
      ST_BUS: begin
        // An ack on the terminal-count cycle takes priority over the timeout
        if (bus_ack) begin
          state_d   = ST_IDLE;
          bus_req_d = 1'b0;
          if (bus_we_q) begin
            wb_rd_addr_d = '0;
          end else begin
            wb_rd_addr_d = rd_q;
            wb_rd_data_d = load_data;
          end
        end else if (tmo_terminal) begin
          state_d      = ST_IDLE;
          bus_req_d    = 1'b0;
          mem_fault_d  = 1'b1;
          wb_rd_addr_d = '0;
        end else begin
          stall_c = 1'b1;
          tmo_d   = tmo_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stall reads as 0 while reset is held, even with a memory op presented
  assign mem_stall = stall_c & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tmo_q        <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_be_q     <= '0;
      bus_wdata_q  <= '0;
      op_q         <= MEM_OP_NONE;
      off_q        <= '0;
      rd_q         <= '0;
      wb_rd_addr_q <= '0;
      wb_rd_data_q <= '0;
      mem_fault_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_be_q     <= bus_be_d;
      bus_wdata_q  <= bus_wdata_d;
      op_q         <= op_d;
      off_q        <= off_d;
      rd_q         <= rd_d;
      wb_rd_addr_q <= wb_rd_addr_d;
      wb_rd_data_q <= wb_rd_data_d;
      mem_fault_q  <= mem_fault_d;
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_be     = bus_be_q;
  assign bus_wdata  = bus_wdata_q;
  assign wb_rd_addr = wb_rd_addr_q;
  assign wb_rd_data = wb_rd_data_q;
  assign mem_fault  = mem_fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Purpose: self-checking bench for mem_stage (directed table, randomized ops vs. reference model, corner sequences).
// Latency: drives one op per call and follows it through the bus handshake to MEM/WB.
// Backpressure: holds mem_params stable while mem_stall is high; acts as the bus responder.
`timescale 1ns/1ps
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TMO = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  mem_params_t     mem_params;
  logic            mem_stall, mem_fault;
  logic [RD_W-1:0] wb_rd_addr;
  logic [31:0]     wb_rd_data;
  logic            bus_req, bus_we;
  logic [31:0]     bus_addr, bus_wdata;
  logic [3:0]      bus_be;
  logic            bus_ack;
  logic [31:0]     bus_rdata;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_params (mem_params),
    .mem_stall  (mem_stall),
    .mem_fault  (mem_fault),
    .wb_rd_addr (wb_rd_addr),
    .wb_rd_data (wb_rd_data),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One op plus the expected outcome
  typedef struct {
    mem_op_t         op;
    logic [RD_W-1:0] rd;
    logic [31:0]     ea;
    logic [31:0]     md;
    int              waits;     // wait cycles before ack; >= TMO means no ack
    logic [31:0]     rdata;
    logic            is_bus;
    logic            fault;
    logic            we;
    logic [3:0]      be;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [RD_W-1:0] wb_addr;
    logic            chk_data;
    logic [31:0]     wb_data;
  } vec_t;

  function automatic vec_t mk(mem_op_t op, logic [RD_W-1:0] rd, logic [31:0] ea, logic [31:0] md,
                              int waits, logic [31:0] rdata, logic is_bus, logic fault, logic we,
                              logic [3:0] be, logic [31:0] addr, logic [31:0] wdata,
                              logic [RD_W-1:0] wb_addr, logic chk_data, logic [31:0] wb_data);
    vec_t v;
    v.op = op; v.rd = rd; v.ea = ea; v.md = md; v.waits = waits; v.rdata = rdata;
    v.is_bus = is_bus; v.fault = fault; v.we = we; v.be = be; v.addr = addr; v.wdata = wdata;
    v.wb_addr = wb_addr; v.chk_data = chk_data; v.wb_data = wb_data;
    return v;
  endfunction

  // Reference model: access size, alignment and lane arithmetic from the op rules
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    int          size, off;
    bit          ld, sgn;
    logic [31:0] mask, val;
    r = v;
    size = 0; ld = 0; sgn = 0;
    off = int'(v.ea % 32'd4);
    case (v.op)
      MEM_OP_LB:  begin size = 1; ld = 1; sgn = 1; end
      MEM_OP_LBU: begin size = 1; ld = 1; end
      MEM_OP_LH:  begin size = 2; ld = 1; sgn = 1; end
      MEM_OP_LHU: begin size = 2; ld = 1; end
      MEM_OP_LW:  begin size = 4; ld = 1; end
      MEM_OP_SB:  size = 1;
      MEM_OP_SH:  size = 2;
      MEM_OP_SW:  size = 4;
      default:    size = 0;
    endcase
    r.is_bus = 0; r.fault = 0; r.we = 0; r.be = '0; r.addr = '0; r.wdata = '0;
    r.wb_addr = '0; r.chk_data = 0; r.wb_data = '0;
    if (size == 0) begin
      r.wb_addr = v.rd; r.chk_data = 1; r.wb_data = v.ea;
    end else if (off % size != 0) begin
      r.fault = 1; r.chk_data = 1;
    end else begin
      r.is_bus = 1;
      r.addr   = v.ea - 32'(off);
      r.be     = 4'(((1 << size) - 1) << off);
      r.we     = !ld;
      if (size == 1)      r.wdata = 32'(v.md[7:0]) * 32'h0101_0101;
      else if (size == 2) r.wdata = 32'(v.md[15:0]) * 32'h0001_0001;
      else                r.wdata = v.md;
      if (v.waits >= TMO) begin
        r.fault = 1;
      end else if (ld) begin
        r.wb_addr  = v.rd;
        r.chk_data = 1;
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        val  = (v.rdata >> (8 * off)) & mask;
        if (sgn && val[8 * size - 1]) val = val | ~mask;
        r.wb_data = val;
      end
    end
    return r;
  endfunction

  // Entry and exit: #1 after a rising edge, DUT in IDLE
  task automatic run_op(input vec_t v, input string tag);
    int stall_cnt;
    int exp_stall;
    bit done;
    stall_cnt = 0;
    done = 0;
    mem_params.rd_addr  = v.rd;
    mem_params.mem_op   = v.op;
    mem_params.rd_data  = v.ea;
    mem_params.mem_data = v.md;
    bus_ack   = 1'b0;
    bus_rdata = $urandom;
    #1;
    chk({tag, ".stall_issue"}, 32'(mem_stall), 32'(v.is_bus));
    if (mem_stall) stall_cnt++;
    @(posedge clk); #1;
    if (v.is_bus) begin
      for (int c = 0; c < TMO && !done; c++) begin
        chk({tag, ".bus_req"}, 32'(bus_req), 32'd1);
        chk({tag, ".bus_we"}, 32'(bus_we), 32'(v.we));
        chk({tag, ".bus_addr"}, bus_addr, v.addr);
        chk({tag, ".bus_be"}, 32'(bus_be), 32'(v.be));
        if (v.we) chk({tag, ".bus_wdata"}, bus_wdata, v.wdata);
        bus_ack   = (c == v.waits);
        bus_rdata = bus_ack ? v.rdata : $urandom;
        #1;
        chk({tag, ".stall_bus"}, 32'(mem_stall), 32'((c != v.waits) && (c != TMO - 1)));
        if (mem_stall) stall_cnt++;
        done = bus_ack || (c == TMO - 1);
        @(posedge clk); #1;
        bus_ack = 1'b0;
      end
    end
    exp_stall = v.is_bus ? 1 + ((v.waits < TMO - 1) ? v.waits : TMO - 1) : 0;
    chk({tag, ".stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
    chk({tag, ".bus_req_end"}, 32'(bus_req), 32'd0);
    chk({tag, ".fault"}, 32'(mem_fault), 32'(v.fault));
    chk({tag, ".wb_rd_addr"}, 32'(wb_rd_addr), 32'(v.wb_addr));
    if (v.chk_data) chk({tag, ".wb_rd_data"}, wb_rd_data, v.wb_data);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".bus_req"}, 32'(bus_req), 32'd0);
    chk({tag, ".bus_we"}, 32'(bus_we), 32'd0);
    chk({tag, ".bus_addr"}, bus_addr, 32'd0);
    chk({tag, ".bus_be"}, 32'(bus_be), 32'd0);
    chk({tag, ".bus_wdata"}, bus_wdata, 32'd0);
    chk({tag, ".wb_rd_addr"}, 32'(wb_rd_addr), 32'd0);
    chk({tag, ".wb_rd_data"}, wb_rd_data, 32'd0);
    chk({tag, ".mem_fault"}, 32'(mem_fault), 32'd0);
    chk({tag, ".mem_stall"}, 32'(mem_stall), 32'd0);
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    int   k;

    tbl.push_back(mk(MEM_OP_NONE, 5'd3,  32'h1234_5678, 32'h0, 0, 32'h0,
                     1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd3, 1'b1, 32'h1234_5678));
    tbl.push_back(mk(MEM_OP_LB,   5'd5,  32'h103, 32'h0, 0, 32'h80FF_0000,
                     1'b1, 1'b0, 1'b0, 4'b1000, 32'h100, 32'h0, 5'd5, 1'b1, 32'hFFFF_FF80));
    tbl.push_back(mk(MEM_OP_LBU,  5'd6,  32'h103, 32'h0, 0, 32'h80FF_0000,
                     1'b1, 1'b0, 1'b0, 4'b1000, 32'h100, 32'h0, 5'd6, 1'b1, 32'h0000_0080));
    tbl.push_back(mk(MEM_OP_SH,   5'd7,  32'h202, 32'hDEAD_BEEF, 3, 32'h0,
                     1'b1, 1'b0, 1'b1, 4'b1100, 32'h200, 32'hBEEF_BEEF, 5'd0, 1'b0, 32'h0));
    tbl.push_back(mk(MEM_OP_LW,   5'd8,  32'h6, 32'h0, 0, 32'h0,
                     1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b1, 32'h0));
    tbl.push_back(mk(MEM_OP_LH,   5'd9,  32'h10, 32'h0, 99, 32'h0,
                     1'b1, 1'b1, 1'b0, 4'b0011, 32'h10, 32'h0, 5'd0, 1'b0, 32'h0));
    tbl.push_back(mk(MEM_OP_LH,   5'd9,  32'h10, 32'h0, 3, 32'h1234_8001,
                     1'b1, 1'b0, 1'b0, 4'b0011, 32'h10, 32'h0, 5'd9, 1'b1, 32'hFFFF_8001));
    tbl.push_back(mk(MEM_OP_LHU,  5'd10, 32'h12, 32'h0, 1, 32'h8001_0000,
                     1'b1, 1'b0, 1'b0, 4'b1100, 32'h10, 32'h0, 5'd10, 1'b1, 32'h0000_8001));
    tbl.push_back(mk(MEM_OP_SB,   5'd11, 32'h1, 32'h0000_00A5, 2, 32'h0,
                     1'b1, 1'b0, 1'b1, 4'b0010, 32'h0, 32'hA5A5_A5A5, 5'd0, 1'b0, 32'h0));
    tbl.push_back(mk(MEM_OP_SW,   5'd12, 32'h20, 32'hCAFE_F00D, 0, 32'h0,
                     1'b1, 1'b0, 1'b1, 4'b1111, 32'h20, 32'hCAFE_F00D, 5'd0, 1'b0, 32'h0));
    tbl.push_back(mk(MEM_OP_LW,   5'd13, 32'h24, 32'h0, 0, 32'h89AB_CDEF,
                     1'b1, 1'b0, 1'b0, 4'b1111, 32'h24, 32'h0, 5'd13, 1'b1, 32'h89AB_CDEF));
    tbl.push_back(mk(MEM_OP_SH,   5'd14, 32'h203, 32'h1111_2222, 0, 32'h0,
                     1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b1, 32'h0));
    tbl.push_back(mk(MEM_OP_LB,   5'd15, 32'h102, 32'h0, 1, 32'h007F_0000,
                     1'b1, 1'b0, 1'b0, 4'b0100, 32'h100, 32'h0, 5'd15, 1'b1, 32'h0000_007F));
    tbl.push_back(mk(MEM_OP_SW,   5'd16, 32'h21, 32'h0, 0, 32'h0,
                     1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b1, 32'h0));

    rst_n      = 1'b0;
    mem_params = '0;
    bus_ack    = 1'b0;
    bus_rdata  = '0;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 300; i++) begin
      k = int'($urandom_range(0, 9));
      v.op    = (k > 8) ? MEM_OP_NONE : mem_op_t'(k);
      v.rd    = RD_W'($urandom_range(1, 31));
      v.ea    = $urandom;
      v.md    = $urandom;
      v.waits = int'($urandom_range(0, 5));
      v.rdata = $urandom;
      run_op(model(v), $sformatf("rnd%0d", i));
    end

    // Ack while idle must not complete the access the stage is just issuing
    run_op(mk(MEM_OP_NONE, 5'd17, 32'h0000_A5A5, 32'h0, 0, 32'h0,
              1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd17, 1'b1, 32'h0000_A5A5), "pre_idle_ack");
    mem_params.rd_addr  = 5'd4;
    mem_params.mem_op   = MEM_OP_LW;
    mem_params.rd_data  = 32'h40;
    mem_params.mem_data = 32'h0;
    bus_ack   = 1'b1;
    bus_rdata = 32'h0000_0055;
    @(posedge clk); #1;
    chk("idle_ack.bus_req", 32'(bus_req), 32'd1);
    chk("idle_ack.wb_rd_addr", 32'(wb_rd_addr), 32'd17);
    chk("idle_ack.fault", 32'(mem_fault), 32'd0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("idle_ack.done_req", 32'(bus_req), 32'd0);
    chk("idle_ack.wb_rd_addr2", 32'(wb_rd_addr), 32'd4);
    chk("idle_ack.wb_rd_data", wb_rd_data, 32'h0000_0055);

    // Reset while a load waits on the bus; a late ack is ignored
    mem_params.rd_addr = 5'd9;
    mem_params.mem_op  = MEM_OP_LW;
    mem_params.rd_data = 32'h80;
    @(posedge clk); #1;
    chk("rst_mid.bus_req_before", 32'(bus_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    bus_ack   = 1'b1;
    bus_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk_reset_outputs("rst_late_ack");
    bus_ack    = 1'b0;
    mem_params = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(mk(MEM_OP_LW, 5'd10, 32'h0, 32'h0, 1, 32'h1357_9BDF,
              1'b1, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h0, 5'd10, 1'b1, 32'h1357_9BDF), "post_rst_lw");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the MINA2000 pipeline, sitting between the EX/MEM and MEM/WB pipeline registers. It consumes the `mem_params_t` bundle produced by execute, performs byte, half-word or word loads and stores over a single-outstanding valid/ack data bus, and stalls the pipeline while a bus transaction is in flight. It owns the MEM/WB register: it forwards ALU and link results unchanged, and it sign- or zero-extends load data before writeback.

## Interface
- `TIMEOUT_CYCLES`, default 256: cycles in BUS without `bus_ack` before the access is aborted. 0 disables the timeout.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_params`  in  mem_params_t  from EX/MEM:
  - `rd_addr` is the destination register.
  - `mem_op` is the access type.
  - `rd_data` is the ALU result, which is the effective address for memory ops.
  - `mem_data` is the store data.
- `mem_stall`  out  1  combinational; high means EX/MEM and earlier stages hold.
- `mem_fault`  out  1  registered one-cycle pulse on a misaligned access or a bus timeout.
- `wb_rd_addr`  out  width of `rd_addr`  MEM/WB destination register; 0 means no writeback.
- `wb_rd_data`  out  32  MEM/WB writeback data.
- `bus_req`  out  1  registered; transaction valid.
- `bus_we`  out  1  registered; 1 for a store.
- `bus_addr`  out  32  registered; word-aligned address, with bits [1:0] = 0.
- `bus_be`  out  4  registered byte enables; lane i is bits [8i+7:8i].
- `bus_wdata`  out  32  registered store data, replicated across lanes.
- `bus_ack`  in  1  completes the transaction in the cycle it is sampled high while `bus_req` = 1.
- `bus_rdata`  in  32  read data; valid only in the ack cycle of a load.

## Operation
- **mem_op values:** NONE, LB, LBU, LH, LHU, LW, SB, SH, SW. Byte order is little-endian. The effective address is `ea = mem_params.rd_data`.

- **Non-memory op (MEM_OP_NONE):**
  - `wb_rd_addr` and `wb_rd_data` are loaded from `rd_addr` and `rd_data` at the next edge.
  - No stall and no bus activity.

- **FSM states:**
  - **IDLE:**
    - A memory op with a misaligned `ea` (halfword with `ea[0]` = 1, word with `ea[1:0]` ≠ 0) does the following at the next edge: `mem_fault` pulses, the MEM/WB register is loaded with rd_addr = 0 and data = 0, and the state stays IDLE. `mem_stall` stays 0.
    - An aligned memory op does the following at the next edge: `bus_*` are registered, `bus_req` = 1, the timeout counter clears, and the state goes to BUS. `mem_stall` = 1 in this cycle.
  - **BUS:**
    - `bus_*` are held stable.
    - `mem_stall = !bus_ack`.
    - When `bus_ack` = 1, at that edge:
      - `bus_req` drops to 0 and the state returns to IDLE.
      - For a load, MEM/WB receives `rd_addr` and the extracted data.
      - For a store, MEM/WB receives rd_addr = 0.
    - The timeout counter increments on every cycle without an ack.
    - When it reaches TIMEOUT_CYCLES − 1 without an ack: `mem_stall` = 0 in that cycle, and at the edge `bus_req` drops, `mem_fault` pulses, MEM/WB receives rd_addr = 0, and the state goes to IDLE.

- **Byte enables:**
  - Byte access: `be = 1 << ea[1:0]`.
  - Halfword access: `be = 4'b0011 << ea[1:0]`.
  - Word access: `be = 4'b1111`.

- **Store data replication:**
  - SB writes `{4{mem_data[7:0]}}`.
  - SH writes `{2{mem_data[15:0]}}`.
  - SW writes `mem_data`.

- **Load extraction:**
  - The byte lane is `ea[1:0]` and the halfword lane is `ea[1]`, both taken from the registered address offset.
  - LB and LH sign-extend to 32 bits.
  - LBU and LHU zero-extend.
  - LW passes `bus_rdata` unchanged.

- **Never-accept condition:** while in BUS, the stage never accepts a new op. The input is held by the stall.

## Timing
- **Reset values:**
  - State is IDLE and the timeout counter is 0.
  - `bus_req`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`, `wb_rd_addr`, `wb_rd_data` and `mem_fault` are all 0.
  - `mem_stall` is 0.
- **Reset asserted in BUS:**
  - `bus_req` falls asynchronously.
  - Any late `bus_ack` is ignored.
- **Non-memory op latency:** 1 cycle from EX/MEM to MEM/WB.
- **Memory op latency:** 2 + W cycles, where W is the number of wait cycles before ack.
  - Op present at cycle N.
  - `bus_req` high from cycle N+1.
  - Earliest ack at cycle N+1.
  - MEM/WB updates at the edge ending the ack cycle.
  - `mem_stall` is high for cycles N through N+W.
- **Ack outside BUS:** `bus_ack` while `bus_req` = 0 is ignored.
- **Ack on the timeout cycle:** when ack and the timeout terminal count coincide, the ack wins and there is no fault.

## Test plan
1. **Pass-through:** MEM_OP_NONE, rd_addr = 3, rd_data = 0x1234_5678 → next cycle `wb_rd_addr` = 3, `wb_rd_data` = 0x1234_5678, `mem_stall` never high.
2. **Byte load with sign extension:** LB at ea = 0x103, ack after 0 waits with rdata = 0x80FF_0000 → `bus_addr` = 0x100, `bus_be` = 4'b1000, `wb_rd_data` = 0xFFFF_FF80, stall high exactly 1 cycle. Repeat with LBU → 0x0000_0080.
3. **Halfword store with wait states:** SH at ea = 0x202, mem_data = 0xDEAD_BEEF, ack after 3 waits → `bus_we` = 1, `bus_be` = 4'b1100, `bus_wdata` = 0xBEEF_BEEF, `bus_*` stable for all 4 cycles, stall high 4 cycles, `wb_rd_addr` = 0.
4. **Misaligned access:** LW at ea = 0x6 → no `bus_req`, one-cycle `mem_fault`, `wb_rd_addr` = 0, no stall.
5. **Timeout:** TIMEOUT_CYCLES = 4, LH at 0x10, no ack → `bus_req` high 4 cycles then low, `mem_fault` pulse, state returns to IDLE. Repeat with ack on the 4th cycle → no fault, data written back.
6. **Reset mid-operation:** `rst_n` low while in BUS → `bus_req` = 0 immediately and all outputs at reset values. A following LW at 0x0 completes normally.
